// File: rtl/cache_pkg.sv
// Shared definitions for the L2 port arbiter: parameter defaults, FSM state
// encoding and a saturating counter helper.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH    = 11;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_L1_BLOCK_SIZE = 16;

  localparam logic [15:0] GRANT_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == GRANT_CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. last_grant holds the index of the previous
// winner; on a tie the other requester wins. Output grant is one-hot or zero.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Single requester wins outright; a tie goes to the one not served last.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Arbitrates two L1 requesters onto one shared L2 request port.
//
// Handshake: a requester raises reqN_read and/or reqN_write (write wins when
// both are set) with addr/wdata and holds them until reqN_ready pulses for
// one cycle; rdata/hit are valid with that pulse and held afterwards. On the
// L2 side exactly one of l2_read/l2_write is held with stable addr/wdata
// until l2_ready is seen high on a rising edge; l2_ready at any other time is
// ignored. While a requester's ready pulse is visible its request is not
// sampled, so a level request cannot be served twice.
module l2_port_arbiter
  import cache_pkg::*;
#(
  parameter int  ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int  DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int  L1_BLOCK_SIZE = DEF_L1_BLOCK_SIZE,
  localparam int BW            = L1_BLOCK_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req0_read,
  input  logic                  req0_write,
  input  logic [BW-1:0]         req0_wdata,
  output logic [BW-1:0]         req0_rdata,
  output logic                  req0_ready,
  output logic                  req0_hit,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic                  req1_read,
  input  logic                  req1_write,
  input  logic [BW-1:0]         req1_wdata,
  output logic [BW-1:0]         req1_rdata,
  output logic                  req1_ready,
  output logic                  req1_hit,
  output logic [ADDR_WIDTH-1:0] l2_addr,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [BW-1:0]         l2_wdata,
  input  logic [BW-1:0]         l2_rdata,
  input  logic                  l2_ready,
  input  logic                  l2_hit,
  output logic [15:0]           grant_cnt0,
  output logic [15:0]           grant_cnt1,
  output arb_state_e            dbg_state
);

  logic [1:0]            req_vec;
  logic [1:0]            grant;
  logic                  last_grant;
  logic                  win;
  logic                  lat_write;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [BW-1:0]         lat_wdata;
  logic [BW-1:0]         cap_rdata;
  logic                  cap_hit;

  // A requester whose ready pulse is currently visible is masked out.
  assign req_vec = {(req1_read | req1_write) & ~req1_ready,
                    (req0_read | req0_write) & ~req0_ready};

  rr_arb2 u_rr_arb2 (
    .req        (req_vec),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Transaction FSM with all outputs registered; reset aborts any transaction.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      dbg_state  <= IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cap_rdata  <= '0;
      cap_hit    <= 1'b0;
      l2_addr    <= '0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_wdata   <= '0;
      req0_ready <= 1'b0;
      req0_rdata <= '0;
      req0_hit   <= 1'b0;
      req1_ready <= 1'b0;
      req1_rdata <= '0;
      req1_hit   <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      req0_ready <= 1'b0;
      req1_ready <= 1'b0;
      case (dbg_state)
        IDLE: begin
          if (grant != 2'b00) begin
            win        <= grant[1];
            last_grant <= grant[1];
            lat_addr   <= grant[1] ? req1_addr  : req0_addr;
            lat_wdata  <= grant[1] ? req1_wdata : req0_wdata;
            lat_write  <= grant[1] ? req1_write : req0_write;
            dbg_state  <= ISSUE;
          end
        end
        ISSUE: begin
          l2_addr   <= lat_addr;
          l2_wdata  <= lat_wdata;
          l2_write  <= lat_write;
          l2_read   <= ~lat_write;
          dbg_state <= WAIT;
        end
        WAIT: begin
          if (l2_ready) begin
            cap_rdata <= l2_rdata;
            cap_hit   <= l2_hit;
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
            dbg_state <= RESP;
          end
        end
        RESP: begin
          if (win) begin
            req1_ready <= 1'b1;
            req1_rdata <= cap_rdata;
            req1_hit   <= cap_hit;
            grant_cnt1 <= sat_inc(grant_cnt1);
          end else begin
            req0_ready <= 1'b1;
            req0_rdata <= cap_rdata;
            req0_hit   <= cap_hit;
            grant_cnt0 <= sat_inc(grant_cnt0);
          end
          dbg_state <= IDLE;
        end
        default: dbg_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: reset checks, a directed vector
// table, hand-written reset/saturation sequences and randomized two-requester
// traffic scored against a transaction-level round-robin model.
module tb_l2_port_arbiter;
  import cache_pkg::*;

  localparam int AW = 11;
  localparam int BW = 128;
  localparam int EW = 1 + AW + BW;
  localparam int CW = 160;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] req0_addr, req1_addr, l2_addr;
  logic req0_read, req0_write, req1_read, req1_write;
  logic [BW-1:0] req0_wdata, req1_wdata, req0_rdata, req1_rdata;
  logic req0_ready, req1_ready, req0_hit, req1_hit;
  logic l2_read, l2_write, l2_ready, l2_hit;
  logic [BW-1:0] l2_wdata, l2_rdata;
  logic [15:0] grant_cnt0, grant_cnt1;
  arb_state_e dbg_state;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] wdata;
  } job_t;

  typedef struct {
    int            who;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    wbyte;
    int            lat;
    logic          exp_write;
    logic [7:0]    exp_byte;
    logic          exp_hit;
    int            exp_cycles;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int fixed_lat = 0;
  logic [15:0] g_cnt[2];
  logic m_last;

  l2_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_addr(req0_addr), .req0_read(req0_read), .req0_write(req0_write),
    .req0_wdata(req0_wdata), .req0_rdata(req0_rdata), .req0_ready(req0_ready),
    .req0_hit(req0_hit),
    .req1_addr(req1_addr), .req1_read(req1_read), .req1_write(req1_write),
    .req1_wdata(req1_wdata), .req1_rdata(req1_rdata), .req1_ready(req1_ready),
    .req1_hit(req1_hit),
    .l2_addr(l2_addr), .l2_read(l2_read), .l2_write(l2_write), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready), .l2_hit(l2_hit),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // L2 contents as seen by this bench: every byte of a block is addr[7:0]+0x65,
  // hit when bits 6:4 of the address have odd parity.
  function automatic logic [BW-1:0] l2_data(input logic [AW-1:0] a);
    logic [7:0] b;
    b = a[7:0] + 8'h65;
    return {16{b}};
  endfunction

  function automatic logic l2_hit_fn(input logic [AW-1:0] a);
    return ^a[6:4];
  endfunction

  task automatic drive_req(input int n, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] wd);
    if (n == 0) begin
      req0_read = rd; req0_write = wr; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_read = rd; req1_write = wr; req1_addr = a; req1_wdata = wd;
    end
  endtask

  function automatic job_t rand_job();
    job_t j;
    int kind;
    kind    = $urandom_range(0, 2);
    j.rd    = (kind != 1);
    j.wr    = (kind != 0);
    j.addr  = AW'($urandom_range(0, 2047));
    j.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    return j;
  endfunction

  // ---------------- L2 responder ----------------
  // Checks each L2 op against the expected order, holds it for a latency,
  // then returns data. Outside an op it drives stray l2_ready and junk data.
  initial begin
    logic [EW-1:0] seen;
    logic [EW-1:0] exp;
    int  lat;
    bit  stable;
    bit  aborted;
    l2_ready = 1'b0;
    l2_rdata = '0;
    l2_hit   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n && (l2_read || l2_write)) begin
        l2_ready = 1'b0;
        seen = {l2_write, l2_addr, l2_wdata};
        check("l2_single_op", CW'(l2_read ^ l2_write), CW'(1));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL l2_unexpected_op: got %0h expected none", seen);
        end else begin
          exp = exp_q.pop_front();
          check("l2_request", CW'(seen), CW'(exp));
        end
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 6);
        stable  = 1'b1;
        aborted = 1'b0;
        for (int i = 1; i < lat; i++) begin
          @(posedge clk); #1;
          if (rst_n) begin
            aborted = 1'b1;
            break;
          end
          if ({l2_write, l2_addr, l2_wdata} !== seen || !(l2_read ^ l2_write)) stable = 1'b0;
        end
        if (!aborted) begin
          check("l2_stable_in_wait", CW'(stable), CW'(1));
          l2_ready = 1'b1;
          l2_rdata = l2_data(l2_addr);
          l2_hit   = l2_hit_fn(l2_addr);
          @(posedge clk); #1;
          l2_ready = 1'b0;
          l2_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
          l2_hit   = ~l2_hit;
          if (!rst_n) check("l2_op_dropped", CW'({l2_read, l2_write}), CW'(0));
        end
      end else begin
        l2_ready = 1'($urandom_range(0, 1));
        l2_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
        l2_hit   = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- requester driver ----------------
  // One transaction: hold the request until ready, check the response and
  // counter, drop the request, then check the pulse lasted one cycle.
  task automatic do_txn(input int n, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [BW-1:0] wd,
                        input logic [BW-1:0] exp_rdata, input logic exp_hit,
                        output int lat);
    bit got = 1'b0;
    int c = 0;
    drive_req(n, rd, wr, a, wd);
    lat = -1;
    while (!got && c < 300) begin
      @(posedge clk); #1;
      c++;
      if ((n == 0) ? req0_ready : req1_ready) got = 1'b1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL req%0d_ready_timeout: got no ready after %0d cycles, expected a pulse", n, c);
      drive_req(n, 1'b0, 1'b0, '0, '0);
    end else begin
      lat = c;
      g_cnt[n] = (g_cnt[n] == 16'hFFFF) ? g_cnt[n] : g_cnt[n] + 16'd1;
      if (n == 0) begin
        check("req0_rdata", CW'(req0_rdata), CW'(exp_rdata));
        check("req0_hit", CW'(req0_hit), CW'(exp_hit));
        check("req1_ready_quiet", CW'(req1_ready), CW'(0));
        check("grant_cnt0", CW'(grant_cnt0), CW'(g_cnt[0]));
      end else begin
        check("req1_rdata", CW'(req1_rdata), CW'(exp_rdata));
        check("req1_hit", CW'(req1_hit), CW'(exp_hit));
        check("req0_ready_quiet", CW'(req0_ready), CW'(0));
        check("grant_cnt1", CW'(grant_cnt1), CW'(g_cnt[1]));
      end
      drive_req(n, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      if (n == 0) begin
        check("req0_ready_one_cycle", CW'(req0_ready), CW'(0));
        check("req0_rdata_hold", CW'(req0_rdata), CW'(exp_rdata));
      end else begin
        check("req1_ready_one_cycle", CW'(req1_ready), CW'(0));
        check("req1_rdata_hold", CW'(req1_rdata), CW'(exp_rdata));
      end
    end
  endtask

  // Both requesters keep their queues busy; the model predicts L2 op order
  // from the round-robin rule over the two queues.
  task automatic run_both_jobs(input job_t j0[$], input job_t j1[$]);
    int i0 = 0;
    int i1 = 0;
    logic w;
    while (i0 < j0.size() || i1 < j1.size()) begin
      if (i0 < j0.size() && i1 < j1.size()) w = ~m_last;
      else w = (i0 < j0.size()) ? 1'b0 : 1'b1;
      if (w == 1'b0) begin
        exp_q.push_back({j0[i0].wr, j0[i0].addr, j0[i0].wdata});
        i0++;
      end else begin
        exp_q.push_back({j1[i1].wr, j1[i1].addr, j1[i1].wdata});
        i1++;
      end
      m_last = w;
    end
    fork
      begin
        int l0;
        foreach (j0[k]) do_txn(0, j0[k].rd, j0[k].wr, j0[k].addr, j0[k].wdata,
                               l2_data(j0[k].addr), l2_hit_fn(j0[k].addr), l0);
      end
      begin
        int l1;
        foreach (j1[m]) do_txn(1, j1[m].rd, j1[m].wr, j1[m].addr, j1[m].wdata,
                               l2_data(j1[m].addr), l2_hit_fn(j1[m].addr), l1);
      end
    join
    check("exp_q_drained", CW'(exp_q.size()), CW'(0));
  endtask

  task automatic run_both(input int n0, input int n1);
    job_t j0[$];
    job_t j1[$];
    for (int i = 0; i < n0; i++) j0.push_back(rand_job());
    for (int i = 0; i < n1; i++) j1.push_back(rand_job());
    run_both_jobs(j0, j1);
  endtask

  task automatic run_single(input int n, input int k);
    job_t j;
    int l;
    for (int i = 0; i < k; i++) begin
      j = rand_job();
      exp_q.push_back({j.wr, j.addr, j.wdata});
      m_last = n[0];
      do_txn(n, j.rd, j.wr, j.addr, j.wdata, l2_data(j.addr), l2_hit_fn(j.addr), l);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_l2_read"}, CW'(l2_read), CW'(0));
    check({tag, "_l2_write"}, CW'(l2_write), CW'(0));
    check({tag, "_l2_addr"}, CW'(l2_addr), CW'(0));
    check({tag, "_l2_wdata"}, CW'(l2_wdata), CW'(0));
    check({tag, "_req0_ready"}, CW'(req0_ready), CW'(0));
    check({tag, "_req1_ready"}, CW'(req1_ready), CW'(0));
    check({tag, "_req0_rdata"}, CW'(req0_rdata), CW'(0));
    check({tag, "_req1_rdata"}, CW'(req1_rdata), CW'(0));
    check({tag, "_req0_hit"}, CW'(req0_hit), CW'(0));
    check({tag, "_req1_hit"}, CW'(req1_hit), CW'(0));
    check({tag, "_grant_cnt0"}, CW'(grant_cnt0), CW'(0));
    check({tag, "_grant_cnt1"}, CW'(grant_cnt1), CW'(0));
    check({tag, "_state"}, CW'(dbg_state), CW'(IDLE));
  endtask

  task automatic apply_reset();
    rst_n = 1'b1;
    g_cnt[0] = '0;
    g_cnt[1] = '0;
    m_last = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[5];
    job_t p0[$];
    job_t p1[$];
    int lat_c;
    logic any_ready;
    logic [BW-1:0] wd;

    // who rd wr addr wbyte lat | exp_write exp_byte exp_hit exp_cycles
    vecs[0] = '{0, 1'b1, 1'b0, 11'h040, 8'h00, 4, 1'b0, 8'hA5, 1'b1, 7};
    vecs[1] = '{1, 1'b0, 1'b1, 11'h3E0, 8'h11, 3, 1'b1, 8'h45, 1'b0, 6};
    vecs[2] = '{0, 1'b1, 1'b1, 11'h155, 8'h3C, 1, 1'b1, 8'hBA, 1'b0, 4};
    vecs[3] = '{1, 1'b1, 1'b0, 11'h7FF, 8'h00, 2, 1'b0, 8'h64, 1'b1, 5};
    vecs[4] = '{0, 1'b0, 1'b1, 11'h000, 8'hFF, 6, 1'b1, 8'h65, 1'b0, 9};

    rst_n = 1'b1;
    drive_req(0, 1'b0, 1'b0, '0, '0);
    drive_req(1, 1'b0, 1'b0, '0, '0);
    g_cnt[0] = '0;
    g_cnt[1] = '0;
    m_last = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_reset_outputs("por");
    rst_n = 1'b0;
    @(posedge clk); #1;

    // Simultaneous first requests after reset: requester 0 goes first.
    p0.push_back('{1'b1, 1'b0, 11'h100, {4{32'hCAFE0000}}});
    p1.push_back('{1'b1, 1'b0, 11'h200, {4{32'h0000BEEF}}});
    run_both_jobs(p0, p1);

    // Ten back-to-back transactions from both: strict alternation.
    apply_reset();
    run_both(5, 5);
    check("alt_grant_cnt0", CW'(grant_cnt0), CW'(16'd5));
    check("alt_grant_cnt1", CW'(grant_cnt1), CW'(16'd5));

    // Directed vectors, one requester at a time, with latency measured.
    for (int v = 0; v < 5; v++) begin
      fixed_lat = vecs[v].lat;
      wd = {16{vecs[v].wbyte}};
      exp_q.push_back({vecs[v].exp_write, vecs[v].addr, wd});
      m_last = vecs[v].who[0];
      do_txn(vecs[v].who, vecs[v].rd, vecs[v].wr, vecs[v].addr, wd,
             {16{vecs[v].exp_byte}}, vecs[v].exp_hit, lat_c);
      check($sformatf("vec%0d_latency", v), CW'(lat_c), CW'(vecs[v].exp_cycles));
      repeat (2) begin @(posedge clk); #1; end
    end
    fixed_lat = 0;

    // Randomized traffic.
    for (int r = 0; r < 6; r++) run_both($urandom_range(1, 6), $urandom_range(1, 6));
    for (int r = 0; r < 4; r++) run_single(r % 2, $urandom_range(1, 4));

    // Reset in the middle of an L2 wait.
    fixed_lat = 30;
    wd = {4{32'h5A5A1234}};
    exp_q.push_back({1'b0, 11'h2A0, wd});
    drive_req(1, 1'b1, 1'b0, 11'h2A0, wd);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_in_wait", CW'({l2_read, dbg_state}), CW'({1'b1, WAIT}));
    rst_n = 1'b1;
    drive_req(1, 1'b0, 1'b0, '0, '0);
    g_cnt[0] = '0;
    g_cnt[1] = '0;
    m_last = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("mid_wait");
    rst_n = 1'b0;
    fixed_lat = 0;
    any_ready = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      any_ready = any_ready | req0_ready | req1_ready;
    end
    check("no_ready_after_abort", CW'(any_ready), CW'(0));
    run_both(1, 1);

    // Counter saturation.
    force dut.grant_cnt0 = 16'hFFFE;
    @(posedge clk); #1;
    release dut.grant_cnt0;
    g_cnt[0] = 16'hFFFE;
    run_single(0, 3);
    check("grant_cnt0_saturated", CW'(grant_cnt0), CW'(16'hFFFF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, byte address width.
REQ-002 Parameter DATA_WIDTH, default 8, bits per byte lane.
REQ-003 Parameter L1_BLOCK_SIZE, default 16, bytes per L1 block; BW = L1_BLOCK_SIZE*DATA_WIDTH.
REQ-004 Reset rst_n, asynchronous, active-high; clock clk.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst_n  in  1  asynchronous reset, active-high.
REQ-007 reqN_addr  in  ADDR_WIDTH  requester N block address, N in {0,1}.
REQ-008 reqN_read / reqN_write  in  1 each  requester N level request, held until reqN_ready.
REQ-009 reqN_wdata  in  BW  requester N write-back block.
REQ-010 reqN_rdata  out  BW  block returned to requester N.
REQ-011 reqN_ready  out  1  one-cycle completion pulse to requester N.
REQ-012 reqN_hit  out  1  L2 hit status for requester N's transaction, valid with reqN_ready.
REQ-013 l2_addr, l2_read, l2_write, l2_wdata  out  ADDR_WIDTH/1/1/BW  shared L2 request port.
REQ-014 l2_rdata, l2_ready, l2_hit  in  BW/1/1  L2 response.
REQ-015 grant_cnt0, grant_cnt1  out  16 each  saturating count of completed transactions per requester.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: if any reqN_read|reqN_write, select winner, latch its addr, wdata, and op into internal registers, go ISSUE; else stay.
REQ-018 Selection is round-robin: one requester active -> it wins; both active -> winner is the requester not in last_grant.
REQ-019 last_grant updates to the winner when the IDLE->ISSUE transition occurs.
REQ-020 ISSUE: drive l2_addr/l2_wdata from latched registers; assert l2_read or l2_write (exactly one); go WAIT.
REQ-021 WAIT: hold l2_* outputs stable; on l2_ready=1, capture l2_rdata and l2_hit, deassert l2_read/l2_write next cycle, go RESP.
REQ-022 RESP: pulse winner's reqN_ready for one cycle with captured data/hit on reqN_rdata/reqN_hit; other requester's ready stays 0; go IDLE.
REQ-023 Minimum latency: request sampled in IDLE at edge T -> l2 op visible after T+1 -> reqN_ready at edge after l2_ready +1; total = L2 latency + 3 cycles.
REQ-024 Read and write both asserted by the same requester: treated as write; read ignored.
REQ-025 Requester deasserting mid-transaction: L2 transaction completes; ready pulse still issued.
REQ-026 A requester's new request during RESP is not sampled until IDLE (no back-to-back in same cycle).
REQ-027 l2_ready asserted outside WAIT is ignored.
REQ-028 grant_cntN increments by 1 in RESP for winner N; holds at 16'hFFFF (no wrap).
REQ-029 reqN_rdata/reqN_hit hold last captured value for requester N until its next RESP.

Reset
REQ-030 While rst_n=1: state IDLE, l2_read=l2_write=0, l2_addr=0, l2_wdata=0, reqN_ready=0, reqN_rdata=0, reqN_hit=0, grant_cntN=0, last_grant=1 (requester 0 wins first tie).
REQ-031 Reset asserted mid-transaction aborts immediately; no ready pulse issued after release.

Structure
REQ-032 Shared package cache_pkg holds ADDR_WIDTH, DATA_WIDTH, L1_BLOCK_SIZE defaults and the FSM state enum typedef.
REQ-033 Sub-module rr_arb2: combinational 2-way round-robin pick from (req vector, last_grant) -> one-hot grant.

Verification
REQ-034 Req0 read 0x040 alone, L2 ready after 4 cycles, hit=1, rdata=0xA5 repeated -> req0_ready single pulse 7 cycles after request, req0_rdata=0xA5.., req0_hit=1, grant_cnt0=1.
REQ-035 Both read simultaneously after reset (0x100, 0x200) -> req0 served first with l2_addr=0x100, then req1 with l2_addr=0x200; each ready pulsed once.
REQ-036 Both continuously requesting for 10 transactions -> grants strictly alternate 0,1,0,1..., grant_cnt0=grant_cnt1=5.
REQ-037 Req1 write 0x3E0 with wdata=0x11.. -> l2_write=1, l2_read=0, l2_wdata=0x11.., stable through WAIT.
REQ-038 Reset asserted during WAIT -> all outputs zero next edge, no reqN_ready after release, first tie goes to requester 0.
REQ-039 Force grant_cnt0 to 0xFFFE, complete 3 req0 transactions -> grant_cnt0=0xFFFF.
